// File: rtl/cdb_pkg.sv
// Purpose: shared CDB constants: default widths, producer priority indices, producer count.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cdb_pkg;

    // Default CDB beat widths
    localparam int CDB_DEF_DATA_WIDTH   = 4;
    localparam int CDB_DEF_TAG_WIDTH    = 4;

    // Default aging threshold for the fixed-priority scheduler
    localparam int CDB_DEF_STARVE_LIMIT = 3;

    // Producer indices on the CDB; lower index = higher fixed priority
    localparam int CDB_OUT_ALU_PRIO     = 0;
    localparam int CDB_OUT_EU1_PRIO     = 1;
    localparam int CDB_OUT_EU2_PRIO     = 2;
    localparam int CDB_OUT_LOAD_PRIO    = 3;

    localparam int CDB_OUT_PARTICIPANTS = 4;

endpackage

// File: rtl/cdb_sched_picker.sv
// Purpose: one-hot winner pick: lowest requester inside the priority mask, else lowest requester.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides what a win means.
//
// Ports:
//   i_prio_mask  preferred set (aged requesters, or indices at/after the RR pointer)
//   i_req        request vector
//   o_win        one-hot winner, zero when i_req is zero
module cdb_sched_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_prio_mask,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_win
);

    logic [N-1:0] w_hi;
    logic [N-1:0] w_src;

    assign w_hi  = i_req & i_prio_mask;
    // Preferred requesters first; fall back to the plain request set.
    // With a "at or after pointer" mask this yields wrap-around round robin.
    assign w_src = (|w_hi) ? w_hi : i_req;
    // Isolate the lowest set bit (two's-complement trick)
    assign o_win = w_src & (~w_src + N'(1));

endmodule

// File: rtl/cdb_scheduler.sv
// Purpose: shares the common data bus among PARTICIPANTS producers; same-cycle grant, registered beat.
// Latency: grant combinational in the request cycle; CDB beat exactly 1 cycle after grant.
// Backpressure: producer holds req/tag/data until granted; 1 beat/cycle throughput.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   req/req_tag/req_data per-producer request and payload (slice i = producer i)
//   grant                one-hot or zero, forced zero while rst_n is low
//   cdb_valid/tag/data   registered CDB beat
//
// Build option: define CDB_SCHED_ROUND_ROBIN_EN for round-robin arbitration
// (no aging counters); otherwise fixed priority with starvation aging.
module cdb_scheduler
    import cdb_pkg::*;
#(
    parameter int PARTICIPANTS  = CDB_OUT_PARTICIPANTS,
    parameter int DATA_WIDTH    = CDB_DEF_DATA_WIDTH,
    parameter int CDB_TAG_WIDTH = CDB_DEF_TAG_WIDTH,
    parameter int STARVE_LIMIT  = CDB_DEF_STARVE_LIMIT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [PARTICIPANTS-1:0]               req,
    input  logic [PARTICIPANTS*CDB_TAG_WIDTH-1:0] req_tag,
    input  logic [PARTICIPANTS*DATA_WIDTH-1:0]    req_data,
    output logic [PARTICIPANTS-1:0]               grant,
    output logic                                  cdb_valid,
    output logic [CDB_TAG_WIDTH-1:0]              cdb_tag,
    output logic [DATA_WIDTH-1:0]                 cdb_data
);

    logic [PARTICIPANTS-1:0]  w_mask;
    logic [PARTICIPANTS-1:0]  w_win;
    logic [PARTICIPANTS-1:0]  w_grant;
    logic [CDB_TAG_WIDTH-1:0] w_tag;
    logic [DATA_WIDTH-1:0]    w_data;

    logic                     r_cdb_valid;
    logic [CDB_TAG_WIDTH-1:0] r_cdb_tag;
    logic [DATA_WIDTH-1:0]    r_cdb_data;

`ifdef CDB_SCHED_ROUND_ROBIN_EN
    localparam int PW = (PARTICIPANTS > 1) ? $clog2(PARTICIPANTS) : 1;

    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] w_win_idx;
    logic [PW-1:0] w_rr_nxt;

    // Prefer indices at or after the pointer; the picker wraps to the low ones
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PARTICIPANTS; i++) begin
            w_mask[i] = (i >= int'(r_rr_ptr));
        end
    end

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < PARTICIPANTS; i++) begin
            if (w_grant[i]) begin
                w_win_idx = PW'(i);
            end
        end
    end

    assign w_rr_nxt = (int'(w_win_idx) == PARTICIPANTS - 1) ? '0 : w_win_idx + PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (|w_grant) begin
            r_rr_ptr <= w_rr_nxt;
        end
    end
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] r_wait [PARTICIPANTS];

    // Aged set: requesters that have waited the full limit win over fresh ones
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PARTICIPANTS; i++) begin
            w_mask[i] = (r_wait[i] == CW'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PARTICIPANTS; i++) begin
            if (!rst_n) begin
                r_wait[i] <= '0;
            end else if (!req[i] || w_grant[i]) begin
                r_wait[i] <= '0;
            end else if (r_wait[i] != CW'(STARVE_LIMIT)) begin
                r_wait[i] <= r_wait[i] + CW'(1);
            end
        end
    end
`endif

    cdb_sched_picker #(
        .N (PARTICIPANTS)
    ) u_picker (
        .i_prio_mask (w_mask),
        .i_req       (req),
        .o_win       (w_win)
    );

    // No grant may escape while reset is asserted, even with requests pending
    assign w_grant = w_win & {PARTICIPANTS{rst_n}};

    // Payload mux: grant is one-hot or zero, so an OR-reduction selects
    // the winner's slice and yields zero on an idle cycle.
    always_comb begin
        w_tag  = '0;
        w_data = '0;
        for (int i = 0; i < PARTICIPANTS; i++) begin
            if (w_grant[i]) begin
                w_tag  = w_tag  | req_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
                w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A beat granted in the cycle that ends with reset asserted is dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else begin
            r_cdb_valid <= |w_grant;
            r_cdb_tag   <= w_tag;
            r_cdb_data  <= w_data;
        end
    end

    assign grant     = w_grant;
    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;

endmodule

// File: tb/tb_cdb_scheduler.sv
// Purpose: directed self-checking bench for cdb_scheduler (4 producers, 4-bit widths, limit 3).
// Latency: inputs driven 1 time unit after posedge, outputs sampled 4 units later.
// Backpressure: n/a.
module tb_cdb_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_tag;
    logic [15:0] req_data;
    logic [3:0]  grant;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [3:0]  cdb_data;

    int checks;
    int errors;

    cdb_scheduler #(
        .PARTICIPANTS  (4),
        .DATA_WIDTH    (4),
        .CDB_TAG_WIDTH (4),
        .STARVE_LIMIT  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .grant     (grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // Check grant and the CDB beat in the current cycle
    task automatic chk_cyc(input string name, input logic [3:0] eg, input logic ev,
                           input logic [3:0] et, input logic [3:0] ed);
        #3;
        chk({name, ".grant"}, 32'(grant), 32'(eg));
        chk({name, ".valid"}, 32'(cdb_valid), 32'(ev));
        chk({name, ".tag"},   32'(cdb_tag), 32'(et));
        chk({name, ".data"},  32'(cdb_data), 32'(ed));
    endtask

`ifdef CDB_SCHED_ROUND_ROBIN_EN
    logic [3:0] rr_g [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0001};
    logic [3:0] rr_r [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0101, 4'b0101};
`else
    // Winner index per aging cycle with req=0011 held
    logic [3:0] age_g [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
`endif

    initial begin
        logic [3:0] prev_t;
        logic [3:0] prev_d;
        logic       prev_v;
        checks = 0;
        errors = 0;
        // Producer payloads: p0 1/6, p1 2/3, p2 5/9, p3 7/E
        req_tag  = {4'h7, 4'h5, 4'h2, 4'h1};
        req_data = {4'hE, 4'h9, 4'h3, 4'h6};

        // Reset held over two rising edges with all producers requesting
        rst_n = 1'b0;
        req   = 4'b1111;
        #2;
        chk("rst0.grant", 32'(grant), 32'h0);
        nxt();
        chk_cyc("rst1", 4'b0000, 1'b0, 4'h0, 4'h0);
        nxt();
        rst_n = 1'b1;
        chk_cyc("rel", 4'b0001, 1'b0, 4'h0, 4'h0);
        nxt();
        req = 4'b0000;
        chk_cyc("rel_beat", 4'b0000, 1'b1, 4'h1, 4'h6);

`ifdef CDB_SCHED_ROUND_ROBIN_EN
        // Re-home the pointer to 0
        nxt();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        prev_v = 1'b0;
        prev_t = 4'h0;
        prev_d = 4'h0;
        for (int k = 0; k < 7; k++) begin
            req = rr_r[k];
            chk_cyc($sformatf("rr%0d", k), rr_g[k], prev_v, prev_t, prev_d);
            prev_v = 1'b1;
            prev_t = (rr_g[k] == 4'b0001) ? 4'h1 : (rr_g[k] == 4'b0010) ? 4'h2 :
                     (rr_g[k] == 4'b0100) ? 4'h5 : 4'h7;
            prev_d = (rr_g[k] == 4'b0001) ? 4'h6 : (rr_g[k] == 4'b0010) ? 4'h3 :
                     (rr_g[k] == 4'b0100) ? 4'h9 : 4'hE;
            nxt();
        end
        req = 4'b0000;
        chk_cyc("rr_end", 4'b0000, 1'b1, 4'h1, 4'h6);
`else
        // Single producer
        nxt();
        req = 4'b0100;
        chk_cyc("single", 4'b0100, 1'b0, 4'h0, 4'h0);
        nxt();
        req = 4'b0000;
        chk_cyc("single_beat", 4'b0000, 1'b1, 4'h5, 4'h9);

        // Aging: p1 waits 3 cycles behind p0, then is forced through
        prev_v = 1'b0;
        prev_t = 4'h0;
        prev_d = 4'h0;
        for (int k = 0; k < 5; k++) begin
            nxt();
            req = 4'b0011;
            chk_cyc($sformatf("age%0d", k), age_g[k], prev_v, prev_t, prev_d);
            prev_v = 1'b1;
            prev_t = (age_g[k] == 4'b0010) ? 4'h2 : 4'h1;
            prev_d = (age_g[k] == 4'b0010) ? 4'h3 : 4'h6;
        end
        nxt();
        req = 4'b0000;
        chk_cyc("age_end", 4'b0000, 1'b1, 4'h1, 4'h6);

        // Withdraw: p3 waits 2 cycles, drops, then its counter must restart from 0
        nxt();
        req = 4'b1001;
        chk_cyc("wd0", 4'b0001, 1'b0, 4'h0, 4'h0);
        nxt();
        chk_cyc("wd1", 4'b0001, 1'b1, 4'h1, 4'h6);
        nxt();
        req = 4'b0001;
        chk_cyc("wd_drop", 4'b0001, 1'b1, 4'h1, 4'h6);
        nxt();
        req = 4'b1001;
        chk_cyc("wd2", 4'b0001, 1'b1, 4'h1, 4'h6);
        nxt();
        chk_cyc("wd3", 4'b0001, 1'b1, 4'h1, 4'h6);
        nxt();
        chk_cyc("wd4", 4'b0001, 1'b1, 4'h1, 4'h6);
        nxt();
        // Fresh p0 request still loses to the aged p3
        chk_cyc("wd_aged", 4'b1000, 1'b1, 4'h1, 4'h6);
        nxt();
        req = 4'b0000;
        chk_cyc("wd_beat", 4'b0000, 1'b1, 4'h7, 4'hE);
        nxt();
        chk_cyc("idle", 4'b0000, 1'b0, 4'h0, 4'h0);

        // Reset mid-operation discards the pending beat
        nxt();
        req = 4'b0010;
        chk_cyc("mid_grant", 4'b0010, 1'b0, 4'h0, 4'h0);
        rst_n = 1'b0;
        nxt();
        chk_cyc("mid_rst", 4'b0000, 1'b0, 4'h0, 4'h0);
        nxt();
        rst_n = 1'b1;
        chk_cyc("mid_rereq", 4'b0010, 1'b0, 4'h0, 4'h0);
        nxt();
        req = 4'b0000;
        chk_cyc("mid_beat", 4'b0000, 1'b1, 4'h2, 4'h3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
